// File: rtl/sar_adc_capture.sv
// sar_adc_capture: receives SAR ADC conversions. It synchronizes the
// asynchronous conversion-done strobe, captures the code on its rising edge,
// optionally converts offset-binary to two's complement, averages over
// 2^AVG_LOG2 conversions, and buffers results in a small FIFO.
//
// Output stream handshake: out_valid is high whenever the FIFO holds at least
// one entry and out_data is the head entry; a transfer (pop) happens on a
// rising clk edge where out_valid && out_ready. out_valid never depends on
// out_ready, and out_ready while out_valid=0 has no effect.
module sar_adc_capture #(
    parameter int N_BIT    = 10,
    parameter int AVG_LOG2 = 0,
    parameter int TWOS     = 1,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic [N_BIT-1:0]         adc_dout,
    input  logic                     adc_ready,
    output logic [N_BIT-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = N_BIT + AVG_LOG2;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    // Strobe synchronizer and edge detector
    logic sync1, sync2, sync_d;
    logic capture;

    // Two-flop synchronizer plus a delayed copy for rising-edge detection
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= adc_ready;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign capture = sync2 & ~sync_d;

    // Code conversion and accumulation
    logic [N_BIT-1:0]   code;
    logic [AW-1:0]      code_ext;
    logic               sign_bit;
    logic [AW-1:0]      acc;
    logic [AW-1:0]      sum;
    logic signed [AW-1:0] sum_s;
    logic [AW-1:0]      shr_s;
    logic [AW-1:0]      shr_u;
    logic [AW-1:0]      result_full;
    logic [N_BIT-1:0]   result;
    logic [CW-1:0]      cnt;
    logic               last;
    logic               push;

    assign code     = (TWOS != 0) ? {~adc_dout[N_BIT-1], adc_dout[N_BIT-2:0]} : adc_dout;
    assign sign_bit = (TWOS != 0) & code[N_BIT-1];

    generate
        if (AVG_LOG2 == 0) begin : g_noext
            assign code_ext = code;
        end else begin : g_ext
            assign code_ext = {{AVG_LOG2{sign_bit}}, code};
        end
    endgenerate

    // The signed shift is kept in its own assignment so the unsigned branch
    // of the select cannot turn it into a logical shift.
    assign sum         = acc + code_ext;
    assign sum_s       = sum;
    assign shr_s       = sum_s >>> AVG_LOG2;
    assign shr_u       = sum >> AVG_LOG2;
    assign result_full = (TWOS != 0) ? shr_s : shr_u;
    assign result      = result_full[N_BIT-1:0];
    assign last        = (cnt == CNT_LAST);
    assign push        = capture & last;

    // Accumulator and sample counter; the last sample of a group restarts both
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            acc <= '0;
            cnt <= '0;
        end else if (capture) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Output FIFO
    logic [N_BIT-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    count;
    logic             full, pop, wr_en, drop;

    assign full  = (count == LW'(DEPTH));
    assign pop   = out_valid & out_ready;
    // A pop frees the head slot on the same edge, so a full FIFO still accepts
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    // Storage array; written only on accepted pushes
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= result;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop on the same edge wins over a clear
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)        ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign level     = count;

endmodule

// File: tb/tb_sar_adc_capture.sv
// Directed bench for sar_adc_capture. Three instances share the ADC inputs:
// a: pass-through unsigned, b: pass-through two's complement,
// c: average of 4, two's complement. Each has its own out_ready.
module tb_sar_adc_capture;

    logic       clk = 1'b0;
    logic       rstb;
    logic [9:0] adc_dout;
    logic       adc_ready;
    logic       ovf_clr;
    logic       out_ready_a, out_ready_b, out_ready_c;
    logic [9:0] out_data_a, out_data_b, out_data_c;
    logic       out_valid_a, out_valid_b, out_valid_c;
    logic       ovf_a, ovf_b, ovf_c;
    logic [2:0] level_a, level_b, level_c;

    int n_checks = 0;
    int n_fail   = 0;

    sar_adc_capture #(.N_BIT(10), .AVG_LOG2(0), .TWOS(0), .DEPTH(4)) u_a (
        .clk(clk), .rstb(rstb), .adc_dout(adc_dout), .adc_ready(adc_ready),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .ovf(ovf_a), .ovf_clr(ovf_clr), .level(level_a));

    sar_adc_capture #(.N_BIT(10), .AVG_LOG2(0), .TWOS(1), .DEPTH(4)) u_b (
        .clk(clk), .rstb(rstb), .adc_dout(adc_dout), .adc_ready(adc_ready),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .ovf(ovf_b), .ovf_clr(ovf_clr), .level(level_b));

    sar_adc_capture #(.N_BIT(10), .AVG_LOG2(2), .TWOS(1), .DEPTH(4)) u_c (
        .clk(clk), .rstb(rstb), .adc_dout(adc_dout), .adc_ready(adc_ready),
        .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .ovf(ovf_c), .ovf_clr(ovf_clr), .level(level_c));

    // Clock: rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rstb = 1'b0; adc_ready = 1'b0; adc_dout = '0; ovf_clr = 1'b0;
        out_ready_a = 1'b0; out_ready_b = 1'b0; out_ready_c = 1'b0;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
    endtask

    // Holds the strobe for 4 cycles; the push has happened on return
    task automatic send_code(input logic [9:0] code);
        @(negedge clk);
        adc_dout = code; adc_ready = 1'b1;
        repeat (4) @(negedge clk);
        adc_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Pop instance a once; caller is at a negedge
    task automatic pop_a();
        out_ready_a = 1'b1;
        @(negedge clk);
        out_ready_a = 1'b0;
    endtask

    task automatic pop_c();
        out_ready_c = 1'b1;
        @(negedge clk);
        out_ready_c = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // Inside the reset window all outputs are cleared
        @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_valid_a, ovf_a, level_a, out_data_a} !== 14'h0) begin n_fail++; $display("FAIL reset_hold_a: got %h expected 0", {out_valid_a, ovf_a, level_a, out_data_a}); end
        rstb = 1'b1;
        @(negedge clk);
        // Build up state: a overflows, c holds one result plus a partial group
        for (int i = 1; i <= 5; i++) send_code(10'(i));
        n_checks++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL reset_pre_ovf: got %b expected 1", ovf_a); end
        n_checks++; if (level_c !== 3'd1) begin n_fail++; $display("FAIL reset_pre_level_c: got %0d expected 1", level_c); end
        // Assert reset asynchronously, between clock edges, mid-conversion
        adc_dout = 10'h3FF; adc_ready = 1'b1;
        @(negedge clk);
        #2 rstb = 1'b0;
        #1;
        n_checks++; if ({out_valid_a, ovf_a, level_a, out_data_a} !== 14'h0) begin n_fail++; $display("FAIL reset_async_a: got %h expected 0", {out_valid_a, ovf_a, level_a, out_data_a}); end
        n_checks++; if ({out_valid_c, ovf_c, level_c, out_data_c} !== 14'h0) begin n_fail++; $display("FAIL reset_async_c: got %h expected 0", {out_valid_c, ovf_c, level_c, out_data_c}); end
        adc_ready = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        // Post-reset group: 0,2,4,7 -> 13/4 floor = 3
        send_code(10'h200); send_code(10'h202); send_code(10'h204); send_code(10'h207);
        n_checks++; if (level_c !== 3'd1) begin n_fail++; $display("FAIL reset_post_level_c: got %0d expected 1", level_c); end
        n_checks++; if (out_data_c !== 10'h003) begin n_fail++; $display("FAIL reset_post_avg: got %h expected 003", out_data_c); end
        n_checks++; if (out_data_a !== 10'h200) begin n_fail++; $display("FAIL reset_post_head_a: got %h expected 200", out_data_a); end
        n_checks++; if (out_data_b !== 10'h000) begin n_fail++; $display("FAIL reset_post_head_b: got %h expected 000", out_data_b); end
    endtask

    task automatic test_pass_through();
        do_reset();
        adc_dout = 10'h2A5; adc_ready = 1'b1;       // rises before edge k
        @(negedge clk);                              // after k
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL lat_k: got %b expected 0", out_valid_a); end
        @(negedge clk);                              // after k+1
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL lat_k1: got %b expected 0", out_valid_a); end
        @(negedge clk);                              // after k+2
        n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL lat_k2: got %b expected 1", out_valid_a); end
        n_checks++; if (out_data_a !== 10'h2A5) begin n_fail++; $display("FAIL pt_unsigned: got %h expected 2a5", out_data_a); end
        n_checks++; if (out_data_b !== 10'h0A5) begin n_fail++; $display("FAIL pt_twos: got %h expected 0a5", out_data_b); end
        @(negedge clk);
        adc_ready = 1'b0;
        repeat (3) @(negedge clk);
        // Strobe held long must still capture exactly once
        n_checks++; if (level_a !== 3'd1) begin n_fail++; $display("FAIL pt_single_capture: got %0d expected 1", level_a); end
    endtask

    task automatic test_average();
        do_reset();
        // -1,-2,-1,-2 -> -6/4 floor = -2
        send_code(10'h1FF); send_code(10'h1FE); send_code(10'h1FF);
        n_checks++; if (level_c !== 3'd0) begin n_fail++; $display("FAIL avg_no_early_push: got %0d expected 0", level_c); end
        send_code(10'h1FE);
        n_checks++; if (level_c !== 3'd1) begin n_fail++; $display("FAIL avg_one_push: got %0d expected 1", level_c); end
        n_checks++; if (out_data_c !== 10'h3FE) begin n_fail++; $display("FAIL avg_neg_floor: got %h expected 3fe", out_data_c); end
        send_code(10'h200); send_code(10'h202); send_code(10'h204); send_code(10'h207);
        n_checks++; if (level_c !== 3'd2) begin n_fail++; $display("FAIL avg_second_group: got %0d expected 2", level_c); end
        pop_c();
        n_checks++; if (out_data_c !== 10'h003) begin n_fail++; $display("FAIL avg_pos: got %h expected 003", out_data_c); end
    endtask

    task automatic test_overflow();
        logic [9:0] exp_q[$];
        do_reset();
        for (int i = 1; i <= 6; i++) send_code(10'(i));
        n_checks++; if (level_a !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d expected 4", level_a); end
        n_checks++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf_a); end
        exp_q = '{10'd1, 10'd2, 10'd3, 10'd4};
        while (exp_q.size() > 0) begin
            n_checks++; if (out_data_a !== exp_q[0]) begin n_fail++; $display("FAIL ovf_drain: got %0d expected %0d", out_data_a, exp_q[0]); end
            void'(exp_q.pop_front());
            pop_a();
        end
        n_checks++; if ({out_valid_a, level_a} !== 4'h0) begin n_fail++; $display("FAIL ovf_empty: got %h expected 0", {out_valid_a, level_a}); end
    endtask

    task automatic test_full_pop();
        logic [9:0] exp_q[$];
        do_reset();
        for (int i = 1; i <= 4; i++) send_code(10'(i));
        adc_dout = 10'd5; adc_ready = 1'b1;         // before edge k
        @(negedge clk);                              // after k
        @(negedge clk);                              // after k+1
        out_ready_a = 1'b1;                          // pop on the push edge
        @(negedge clk);                              // after k+2
        out_ready_a = 1'b0;
        n_checks++; if (level_a !== 3'd4) begin n_fail++; $display("FAIL fullpop_level: got %0d expected 4", level_a); end
        n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL fullpop_no_ovf: got %b expected 0", ovf_a); end
        @(negedge clk);
        adc_ready = 1'b0;
        repeat (3) @(negedge clk);
        exp_q = '{10'd2, 10'd3, 10'd4, 10'd5};
        while (exp_q.size() > 0) begin
            n_checks++; if (out_data_a !== exp_q[0]) begin n_fail++; $display("FAIL fullpop_drain: got %0d expected %0d", out_data_a, exp_q[0]); end
            void'(exp_q.pop_front());
            pop_a();
        end
    endtask

    task automatic test_ovf_clr();
        do_reset();
        for (int i = 1; i <= 4; i++) send_code(10'(i));
        adc_dout = 10'd9; adc_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ovf_clr = 1'b1;                              // clear on the overflow edge
        @(negedge clk);
        ovf_clr = 1'b0;
        n_checks++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovfclr_priority: got %b expected 1", ovf_a); end
        @(negedge clk);
        adc_ready = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf_a); end
        n_checks++; if (out_data_a !== 10'd1) begin n_fail++; $display("FAIL ovf_contents: got %0d expected 1", out_data_a); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL ovfclr_idle: got %b expected 0", ovf_a); end
    endtask

    task automatic test_ready_empty();
        do_reset();
        out_ready_a = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (level_a !== 3'd0) begin n_fail++; $display("FAIL empty_ready_level: got %0d expected 0", level_a); end
        adc_dout = 10'h155; adc_ready = 1'b1;
        repeat (3) @(negedge clk);                   // after k+2: push into empty is not popped
        n_checks++; if ({out_valid_a, level_a} !== 4'b1_001) begin n_fail++; $display("FAIL empty_push: got %b expected 1001", {out_valid_a, level_a}); end
        n_checks++; if (out_data_a !== 10'h155) begin n_fail++; $display("FAIL empty_push_data: got %h expected 155", out_data_a); end
        @(negedge clk);                              // popped on the following edge
        n_checks++; if (level_a !== 3'd0) begin n_fail++; $display("FAIL empty_then_pop: got %0d expected 0", level_a); end
        adc_ready = 1'b0; out_ready_a = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rstb = 1'b0; adc_ready = 1'b0; adc_dout = '0; ovf_clr = 1'b0;
        out_ready_a = 1'b0; out_ready_b = 1'b0; out_ready_c = 1'b0;
        test_reset();
        test_pass_through();
        test_average();
        test_overflow();
        test_full_pop();
        test_ovf_clr();
        test_ready_empty();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_adc_capture.md
Name: sar_adc_capture

Overview:
- Digital receiver for the SAR ADC conversion output. It detects each `ready` strobe from the converter and captures `dout`.
- Captured codes are optionally converted from offset-binary to two's complement, then averaged over 2^AVG_LOG2 conversions.
- Results are buffered in a FIFO and presented on a valid/ready stream toward the DSP or bench checker.
- It sits directly behind sar_adc in the sar_adc testbench and the top-level digital backend.

Parameters:
- N_BIT, `ADC_BIT (from sar_adc_def.vh): ADC code width and output sample width.
- AVG_LOG2, 0: log2 of the number of conversions averaged per output sample; 0 = pass-through.
- TWOS, 1: 1 = invert the code MSB (offset-binary to two's complement, signed math); 0 = unsigned math.
- DEPTH, 4: FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rstb  in  1  asynchronous active-low reset.
- adc_dout  in  N_BIT  ADC conversion code; stable while adc_ready is high.
- adc_ready  in  1  ADC conversion-done strobe; asynchronous to clk.
- out_data  out  N_BIT  averaged sample at the FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accept; pop when out_valid && out_ready.
- ovf  out  1  sticky overflow: a sample was dropped because the FIFO was full.
- ovf_clr  in  1  synchronous clear of ovf.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rstb=0, asynchronous):
  - Clears the synchronizer, edge detector, accumulator, sample counter, FIFO pointers and ovf.
  - Outputs: out_data=0, out_valid=0, ovf=0, level=0.
- Reset mid-accumulation discards the partial sum. The first sample after reset starts a new average.
- Synchronizer and capture:
  - adc_ready passes through a 2-flop synchronizer; a registered copy of the synchronized level drives rising-edge detection.
  - A conversion is captured on the clk edge where the synchronized level is 1 and its delayed copy is 0.
  - Input requirement: adc_ready high and adc_dout stable for >= 3 clk cycles. A pulse shorter than 2 cycles may be missed (no error flag).
- Conversion: code = TWOS ? {~adc_dout[N_BIT-1], adc_dout[N_BIT-2:0]} : adc_dout.
- Averager:
  - Accumulator width N_BIT+AVG_LOG2, sign-extended when TWOS=1.
  - Sample counter runs 0..2^AVG_LOG2-1. On each capture: acc += code and cnt += 1.
  - When cnt wraps (the last sample of the group), result = (acc+code) >>> AVG_LOG2. The shift is arithmetic when TWOS=1 (floor toward -inf) and logical when TWOS=0.
  - The same edge pushes the result to the FIFO and clears acc to 0.
  - AVG_LOG2=0: every capture pushes.
- Latency: adc_ready rises before clk edge k → sync1 at k, sync2 at k+1, capture and push at edge k+2. With the FIFO initially empty, out_valid=1 and out_data valid after edge k+2.
- FIFO:
  - First-in first-out; out_data is driven from the head entry.
  - Push and pop in the same cycle: level is unchanged; allowed at full and at empty+push is not a pop.
  - Push while full with no pop: the sample is dropped, FIFO contents are unchanged, and ovf is set.
  - Push while full with a simultaneous pop: the push is accepted and no overflow occurs.
  - Pointers wrap modulo DEPTH.
- ovf: set has priority over ovf_clr in the same cycle. Otherwise ovf_clr=1 clears it on the next edge.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset: assert rstb=0 mid-stream → out_valid=0, level=0, ovf=0, out_data=0 immediately. After release, the first output uses only post-reset samples.
- Pass-through, N_BIT=10, AVG_LOG2=0:
  - TWOS=0, adc_dout=10'h2A5 → out_data=10'h2A5 at edge k+2.
  - TWOS=1, same code → out_data=10'h0A5 (+165).
- Averaging, AVG_LOG2=2, TWOS=1:
  - Codes 0x200, 0x202, 0x204, 0x207 → out_data=3.
  - Codes 0x1FF, 0x1FE, 0x1FF, 0x1FE → out_data=10'h3FE (-2, floor).
  - Only one push per 4 captures.
- Overflow, DEPTH=4, out_ready=0: send 6 conversions 1..6 → level=4 and ovf=1. Then drain with out_ready=1 → outputs 1, 2, 3, 4; values 5 and 6 are lost.
- Full with a simultaneous pop: level=4, pulse out_ready on the exact push edge → level stays 4, ovf stays 0, and drain order is preserved.
- ovf_clr with an overflow on the same edge → ovf remains 1. ovf_clr on a later idle cycle → ovf=0.
